// File: rtl/cmsdk_ahb_mem_responder_pkg.sv
// Shared definitions for the 64-bit AHB-Lite memory responder:
// bus encodings, data-phase state encoding and byte-lane helpers.
package cmsdk_ahb_mem_responder_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings (sizes above doubleword are rejected)
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data-phase state
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Byte-lane enables of a naturally aligned access within a doubleword.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] addr);
        logic [15:0] mask;
        mask = ((16'd1 << (5'd1 << size)) - 16'd1) << addr;
        return mask[7:0];
    endfunction

    // True when the address is not a multiple of the access size.
    function automatic logic misaligned(input logic [2:0] size, input logic [2:0] addr);
        logic mis;
        case (size)
            HSIZE_BYTE:  mis = 1'b0;
            HSIZE_HALF:  mis = addr[0];
            HSIZE_WORD:  mis = |addr[1:0];
            HSIZE_DWORD: mis = |addr;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/cmsdk_ahb_excl_monitor.sv
// Single-entry exclusive-access monitor: one doubleword tag plus a valid bit.
// Updated once per completed OKAY transfer (the cycle the data phase ends).
module cmsdk_ahb_excl_monitor #(
    parameter int TAG_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic             is_write,
    input  logic             is_excl,
    input  logic [TAG_W-1:0] dw_addr,
    output logic             excl_fail
);

    logic             tag_vld;
    logic [TAG_W-1:0] tag;
    logic             match;

    assign match     = tag_vld & (tag == dw_addr);
    assign excl_fail = is_write & is_excl & ~match;

    // Valid bit: set by exclusive reads, cleared by any exclusive write
    // or by an ordinary write hitting the tagged doubleword.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= 1'b0;
        end else if (upd) begin
            if (is_excl & ~is_write) begin
                tag_vld <= 1'b1;
            end else if (is_write & (is_excl | match)) begin
                tag_vld <= 1'b0;
            end
        end
    end

    // Tag captured by each exclusive read; meaningless while invalid.
    always_ff @(posedge clk) begin
        if (upd & is_excl & ~is_write) begin
            tag <= dw_addr;
        end
    end

endmodule

// File: rtl/cmsdk_ahb_mem_responder64.sv
// 64-bit AHB-Lite responder backed by an internal byte-addressable RAM with
// programmable wait states, ERROR responses for bad size/alignment, and an
// optional exclusive monitor enabled by CMSDK_AHB_MEM_RESPONDER_EXCL_EN.
module cmsdk_ahb_mem_responder64
    import cmsdk_ahb_mem_responder_pkg::*;
#(
    parameter int AW          = 16,
    parameter int WAIT_STATES = 0,
    parameter     MessageTag  = "MemResponder:"
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [3:0]  HPROT,
    input  logic        EXREQ,
    input  logic [63:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [63:0] HRDATA,
    output logic        EXRESP
);

    localparam int         DEPTH   = 1 << (AW - 3);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [63:0]   mem [DEPTH];

    state_t        state, state_n;
    logic [3:0]    wait_cnt, wait_cnt_n;
    logic          trans_active;
    logic          ready_int;
    logic          accept;
    logic          addr_err;
    logic [AW-1:0] addr_p1;
    logic [1:0]    size_p1;
    logic          write_p1;
    logic          excl_fail;
    logic          commit;
    logic [7:0]    wr_mask;

    // Only NONSEQ and SEQ carry an access; IDLE and BUSY are ignored.
    always_comb begin
        trans_active = 1'b0;
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
            default:                   trans_active = 1'b0;
        endcase
    end

    // A new address phase is taken only while our own data phase is ready;
    // inside a decoder HREADY already implies that, standalone it is the same wire.
    assign ready_int = (state == ST_IDLE) | (state == ST_LAST) | (state == ST_ERR2);
    assign accept    = HSEL & HREADY & trans_active & ready_int;
    assign addr_err  = HSIZE[2] | misaligned(HSIZE, HADDR[2:0]);

    // Next data-phase state and wait counter.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_n = ST_LAST;
                end else begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: state_n = ST_ERR2;
            default: begin
                state_n = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_n = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_n = ST_LAST;
                    end else begin
                        state_n    = ST_WAIT;
                        wait_cnt_n = WS_LOAD;
                    end
                end
            end
        endcase
    end

    // State register; reset aborts any data phase in flight.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // ---- address phase -> data phase (p1) ----
    // Address-phase attributes held for the data phase.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_p1  <= HADDR[AW-1:0];
            size_p1  <= HSIZE[1:0];
            write_p1 <= HWRITE;
        end
    end

`ifdef CMSDK_AHB_MEM_RESPONDER_EXCL_EN
    logic excl_p1;

    // Exclusive request qualifier held for the data phase.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            excl_p1 <= EXREQ;
        end
    end

    cmsdk_ahb_excl_monitor #(
        .TAG_W (AW - 3)
    ) u_excl_monitor (
        .clk       (HCLK),
        .rst       (HRESET),
        .upd       (state == ST_LAST),
        .is_write  (write_p1),
        .is_excl   (excl_p1),
        .dw_addr   (addr_p1[AW-1:3]),
        .excl_fail (excl_fail)
    );
`else
    assign excl_fail = 1'b0;
`endif

    // LAST always lasts exactly one cycle, so its closing edge is the commit point.
    assign commit  = (state == ST_LAST) & write_p1 & ~excl_fail;
    assign wr_mask = lane_mask(size_p1, addr_p1[2:0]);

    // RAM write: only enabled byte lanes of HWDATA are stored.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int n = 0; n < 8; n++) begin
                if (wr_mask[n]) begin
                    mem[addr_p1[AW-1:3]][8*n +: 8] <= HWDATA[8*n +: 8];
                end
            end
        end
    end

    assign HREADYOUT = ready_int;
    assign HRESP     = ((state == ST_ERR1) | (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state == ST_LAST) ? mem[addr_p1[AW-1:3]] : 64'd0;
    assign EXRESP    = (state == ST_LAST) & excl_fail;

`ifndef SYNTHESIS
    // Diagnostic for every transfer answered with ERROR.
    always @(posedge HCLK) begin
        if (!HRESET && accept && addr_err) begin
            $display("%s ERROR response addr=0x%08h size=%0d write=%0b excl=%0b prot=0x%0h time=%0t",
                     MessageTag, HADDR, HSIZE, HWRITE, EXREQ, HPROT, $time);
        end
    end
`endif

endmodule

// File: tb/tb_cmsdk_ahb_mem_responder64.sv
// Bench for cmsdk_ahb_mem_responder64: one instance with zero wait states and
// one with three, driven in turn, checked against a byte-array memory model.
module tb_cmsdk_ahb_mem_responder64;

    localparam int AW = 10;
`ifdef CMSDK_AHB_MEM_RESPONDER_EXCL_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif

    logic        HCLK;
    logic        HRESET;
    logic        hsel0, hsel3;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [3:0]  HPROT;
    logic        EXREQ;
    logic [63:0] HWDATA;
    logic        rdy0, resp0, ex0, rdy3, resp3, ex3;
    logic [63:0] rdata0, rdata3;

    bit          sel;
    logic        o_rdy, o_resp, o_ex;
    logic [63:0] o_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model: low 256 bytes of each instance plus its exclusive monitor.
    byte unsigned mm [2][256];
    bit           mv [2];
    int           mt [2];

    cmsdk_ahb_mem_responder64 #(.AW(AW), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HPROT(HPROT), .EXREQ(EXREQ), .HWDATA(HWDATA),
        .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0), .EXRESP(ex0));

    cmsdk_ahb_mem_responder64 #(.AW(AW), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HPROT(HPROT), .EXREQ(EXREQ), .HWDATA(HWDATA),
        .HREADY(rdy3), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3), .EXRESP(ex3));

    always_comb begin
        o_rdy   = sel ? rdy3   : rdy0;
        o_resp  = sel ? resp3  : resp0;
        o_rdata = sel ? rdata3 : rdata0;
        o_ex    = sel ? ex3    : ex0;
    end

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model_dw(input bit s, input int a);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = mm[s][(a & ~7) + b];
        return r;
    endfunction

    task automatic bus_idle();
        hsel0 = 1'b0; hsel3 = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; EXREQ = 1'b0;
    endtask

    // One isolated transfer; addr bits [9:8] must be zero (upper bits are free).
    task automatic xfer(input bit s, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, input bit ex, input string tag,
                        output logic [63:0] rd, output logic exo);
        int          lo, exp_waits, waits;
        bit          err, fail;
        logic [63:0] exp_rd;
        lo        = int'(addr[7:0]);
        err       = (size > 3'd3) || ((lo % (1 << size)) != 0);
        exp_waits = err ? 1 : (s ? 3 : 0);
        fail      = !err && EXCL && wr && ex && !(mv[s] && (mt[s] == (lo >> 3)));
        exp_rd    = err ? 64'd0 : model_dw(s, lo);
        sel = s; hsel0 = !s; hsel3 = s;
        HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr; EXREQ = ex;
        HPROT = 4'($urandom);
        @(posedge HCLK); #1;
        bus_idle();
        HADDR  = $urandom;
        HWDATA = wdata;
        waits  = 0;
        @(negedge HCLK);
        while (!o_rdy && waits < 40) begin
            checks++;
            if (o_resp !== err) begin
                errors++; $display("FAIL %s wait-resp got=%b exp=%b", tag, o_resp, err);
            end
            checks++;
            if (o_rdata !== 64'd0) begin
                errors++; $display("FAIL %s wait-rdata got=%h exp=0", tag, o_rdata);
            end
            waits++;
            @(negedge HCLK);
        end
        checks++;
        if (waits !== exp_waits) begin
            errors++; $display("FAIL %s wait-cycles got=%0d exp=%0d", tag, waits, exp_waits);
        end
        checks++;
        if (o_resp !== err) begin
            errors++; $display("FAIL %s resp got=%b exp=%b", tag, o_resp, err);
        end
        if (!wr || err) begin
            checks++;
            if (o_rdata !== exp_rd) begin
                errors++; $display("FAIL %s rdata got=%h exp=%h", tag, o_rdata, exp_rd);
            end
        end
        checks++;
        if (o_ex !== fail) begin
            errors++; $display("FAIL %s exresp got=%b exp=%b", tag, o_ex, fail);
        end
        rd  = o_rdata;
        exo = o_ex;
        if (!err) begin
            if (wr && !fail)
                for (int i = 0; i < (1 << size); i++) mm[s][lo + i] = wdata[8*((lo + i) % 8) +: 8];
            if (EXCL) begin
                if (ex && !wr) begin
                    mv[s] = 1'b1; mt[s] = lo >> 3;
                end else if (wr && ex) begin
                    mv[s] = 1'b0;
                end else if (wr && mv[s] && mt[s] == (lo >> 3)) begin
                    mv[s] = 1'b0;
                end
            end
        end
        @(posedge HCLK); #1;
        HWDATA = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        HRESET = 1'b1; bus_idle(); HADDR = '0; HSIZE = '0; HPROT = '0; HWDATA = '0; sel = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checks++; if (rdy0 !== 1'b1)    begin errors++; $display("FAIL reset rdy0 got=%b exp=1", rdy0); end
        checks++; if (resp0 !== 1'b0)   begin errors++; $display("FAIL reset resp0 got=%b exp=0", resp0); end
        checks++; if (rdata0 !== 64'd0) begin errors++; $display("FAIL reset rdata0 got=%h exp=0", rdata0); end
        checks++; if (ex0 !== 1'b0)     begin errors++; $display("FAIL reset ex0 got=%b exp=0", ex0); end
        checks++; if (rdy3 !== 1'b1)    begin errors++; $display("FAIL reset rdy3 got=%b exp=1", rdy3); end
        checks++; if (resp3 !== 1'b0)   begin errors++; $display("FAIL reset resp3 got=%b exp=0", resp3); end
        checks++; if (rdata3 !== 64'd0) begin errors++; $display("FAIL reset rdata3 got=%h exp=0", rdata3); end
        checks++; if (ex3 !== 1'b0)     begin errors++; $display("FAIL reset ex3 got=%b exp=0", ex3); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        mv[0] = 1'b0; mv[1] = 1'b0;
    endtask

    task automatic preload();
        logic [63:0] rd; logic exo;
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < 32; d++)
                xfer(s[0], 1'b1, 32'(d * 8), 3'd3, {$urandom, $urandom}, 1'b0, "preload", rd, exo);
    endtask

    task automatic test_basic();
        logic [63:0] rd; logic exo;
        xfer(1'b0, 1'b1, 32'h10, 3'd3, 64'h0011223344556677, 1'b0, "basic-wr", rd, exo);
        xfer(1'b0, 1'b0, 32'h10, 3'd3, 64'd0, 1'b0, "basic-rd", rd, exo);
        checks++;
        if (rd !== 64'h0011223344556677) begin
            errors++; $display("FAIL basic-data got=%h exp=0011223344556677", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [63:0] rd, wd; logic exo;
        xfer(1'b1, 1'b1, 32'h10, 3'd3, 64'h0011223344556677, 1'b0, "ws-wr", rd, exo);
        wd = {$urandom, $urandom};
        wd[31:24] = 8'hAB;
        xfer(1'b1, 1'b1, 32'h13, 3'd0, wd, 1'b0, "ws-byte", rd, exo);
        xfer(1'b1, 1'b0, 32'h10, 3'd3, 64'd0, 1'b0, "ws-rd", rd, exo);
        checks++;
        if (rd !== 64'h00112233AB556677) begin
            errors++; $display("FAIL ws-data got=%h exp=00112233ab556677", rd);
        end
    endtask

    task automatic test_error();
        logic [63:0] rd; logic exo;
        for (int s = 0; s < 2; s++) begin
            xfer(s[0], 1'b1, 32'h21, 3'd1, {$urandom, $urandom}, 1'b0, "err-half", rd, exo);
            xfer(s[0], 1'b0, 32'h20, 3'd3, 64'd0, 1'b0, "err-after", rd, exo);
            xfer(s[0], 1'b0, 32'h00, 3'd4, 64'd0, 1'b0, "err-size", rd, exo);
            xfer(s[0], 1'b0, 32'h26, 3'd2, 64'd0, 1'b0, "err-word", rd, exo);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e10, e18, nd;
        e10 = model_dw(1'b0, 32'h10);
        e18 = model_dw(1'b0, 32'h18);
        nd  = {$urandom, $urandom};
        sel = 1'b0; hsel0 = 1'b1; hsel3 = 1'b0;
        HTRANS = 2'b10; HADDR = 32'h10; HSIZE = 3'd3; HWRITE = 1'b0; EXREQ = 1'b0;
        @(posedge HCLK); #1;
        HTRANS = 2'b11; HADDR = 32'hABCD_0018;
        @(negedge HCLK);
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL b2b-rdy1 got=%b exp=1", o_rdy); end
        checks++; if (o_rdata !== e10) begin errors++; $display("FAIL b2b-d10 got=%h exp=%h", o_rdata, e10); end
        @(posedge HCLK); #1;
        HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b1;
        @(negedge HCLK);
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL b2b-rdy2 got=%b exp=1", o_rdy); end
        checks++; if (o_rdata !== e18) begin errors++; $display("FAIL b2b-d18 got=%h exp=%h", o_rdata, e18); end
        @(posedge HCLK); #1;
        HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b0; HWDATA = nd;
        @(negedge HCLK);
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL b2b-rdy3 got=%b exp=1", o_rdy); end
        @(posedge HCLK); #1;
        bus_idle();
        for (int b = 0; b < 8; b++) mm[0][32'h20 + b] = nd[8*b +: 8];
        @(negedge HCLK);
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL b2b-rdy4 got=%b exp=1", o_rdy); end
        checks++; if (o_rdata !== nd) begin errors++; $display("FAIL b2b-raw got=%h exp=%h", o_rdata, nd); end
        @(posedge HCLK); #1;
    endtask

    task automatic test_exclusive();
        logic [63:0] rd, d1, d2, d3; logic exo;
        d1 = {$urandom, $urandom}; d2 = ~d1; d3 = {$urandom, $urandom};
        xfer(1'b0, 1'b0, 32'h40, 3'd3, 64'd0, 1'b1, "ex-rd1", rd, exo);
        xfer(1'b0, 1'b1, 32'h40, 3'd3, d1, 1'b1, "ex-wr1", rd, exo);
        checks++; if (exo !== 1'b0) begin errors++; $display("FAIL ex-wr1-resp got=%b exp=0", exo); end
        xfer(1'b0, 1'b0, 32'h40, 3'd3, 64'd0, 1'b0, "ex-chk1", rd, exo);
        checks++; if (rd !== d1) begin errors++; $display("FAIL ex-chk1-data got=%h exp=%h", rd, d1); end
        xfer(1'b0, 1'b1, 32'h40, 3'd3, d2, 1'b1, "ex-wr2", rd, exo);
        checks++; if (exo !== EXCL) begin errors++; $display("FAIL ex-wr2-resp got=%b exp=%b", exo, EXCL); end
        xfer(1'b0, 1'b0, 32'h40, 3'd3, 64'd0, 1'b0, "ex-chk2", rd, exo);
        xfer(1'b0, 1'b0, 32'h40, 3'd3, 64'd0, 1'b1, "ex-rd3", rd, exo);
        xfer(1'b0, 1'b1, 32'h44, 3'd2, d3, 1'b0, "ex-norm", rd, exo);
        xfer(1'b0, 1'b1, 32'h40, 3'd3, d1, 1'b1, "ex-wr3", rd, exo);
        checks++; if (exo !== EXCL) begin errors++; $display("FAIL ex-wr3-resp got=%b exp=%b", exo, EXCL); end
        xfer(1'b0, 1'b0, 32'h40, 3'd3, 64'd0, 1'b0, "ex-chk3", rd, exo);
    endtask

    task automatic test_random();
        logic [63:0] rd; logic exo;
        bit s, wr, ex; int lo; logic [2:0] size;
        for (int n = 0; n < 150; n++) begin
            s    = 1'($urandom);
            wr   = 1'($urandom);
            ex   = ($urandom_range(0, 3) == 0);
            size = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            lo   = $urandom_range(0, 255);
            if (size <= 3'd3 && $urandom_range(0, 4) != 0) lo = lo & ~((1 << size) - 1);
            xfer(s, wr, ($urandom << AW) | 32'(lo), size, {$urandom, $urandom}, ex, "random", rd, exo);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd, pre; logic exo;
        pre = model_dw(1'b1, 32'h50);
        sel = 1'b1; hsel3 = 1'b1; hsel0 = 1'b0;
        HTRANS = 2'b10; HADDR = 32'h50; HSIZE = 3'd3; HWRITE = 1'b1; EXREQ = 1'b0;
        @(posedge HCLK); #1;
        bus_idle(); HWDATA = ~pre;
        @(negedge HCLK);
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL rstmid-wait got=%b exp=0", o_rdy); end
        #2 HRESET = 1'b1;
        #1;
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL rstmid-rdy got=%b exp=1", o_rdy); end
        checks++; if (o_resp !== 1'b0) begin errors++; $display("FAIL rstmid-resp got=%b exp=0", o_resp); end
        checks++; if (o_rdata !== 64'd0) begin errors++; $display("FAIL rstmid-rdata got=%h exp=0", o_rdata); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        mv[0] = 1'b0; mv[1] = 1'b0;
        xfer(1'b1, 1'b0, 32'h50, 3'd3, 64'd0, 1'b0, "rstmid-rd", rd, exo);
        checks++; if (rd !== pre) begin errors++; $display("FAIL rstmid-keep got=%h exp=%h", rd, pre); end
        // Reset while a read is in its data phase forces HRDATA back to zero.
        sel = 1'b0; hsel0 = 1'b1; hsel3 = 1'b0;
        HTRANS = 2'b10; HADDR = 32'h50; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        checks++; if (o_rdata !== model_dw(1'b0, 32'h50)) begin
            errors++; $display("FAIL rstrd-data got=%h exp=%h", o_rdata, model_dw(1'b0, 32'h50));
        end
        #1 HRESET = 1'b1;
        #1;
        checks++; if (o_rdata !== 64'd0) begin errors++; $display("FAIL rstrd-zero got=%h exp=0", o_rdata); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        mv[0] = 1'b0; mv[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_exclusive();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
